// File: rtl/core_pkg.sv
// Shared types and constants for the i2d core exception path.
package core_pkg;

    localparam int unsigned CORE_AW   = 32;
    localparam int unsigned IRQ_IDX_W = 5;
    localparam int unsigned SR_I      = 2;

    localparam logic [4:0] SPR_EPC   = 5'd1;
    localparam logic [4:0] SPR_ESR   = 5'd2;
    localparam logic [4:0] SPR_IMASK = 5'd3;
    localparam logic [4:0] SPR_ISTAT = 5'd4;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_IRQ,
        CAUSE_SWI,
        CAUSE_IF_ERR,
        CAUSE_ID_ERR,
        CAUSE_MAU_ERR,
        CAUSE_RFE
    } exc_cause_e;

    typedef struct packed {
        logic [CORE_AW-1:0]   epc;
        logic [CORE_AW-1:0]   esr;
        logic                 is_irq;
        logic [IRQ_IDX_W-1:0] irq_idx;
    } exc_frame_t;

endpackage

// File: rtl/core_exc_stack.sv
// LIFO of exception frames; top entry is writable in place for SPR updates.
module core_exc_stack
    import core_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  exc_frame_t         frame_i,
    input  logic               top_we_epc_i,
    input  logic               top_we_esr_i,
    input  logic [CORE_AW-1:0] top_wdata_i,
    output exc_frame_t         top_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LW-1:0]      level_o
);

    localparam int unsigned IW = $clog2(DEPTH);

    exc_frame_t        mem_q [DEPTH];
    logic [LW-1:0]     level_q;
    logic [IW-1:0]     top_idx;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign top_idx = IW'(level_q - LW'(1));
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    // Top-write hits the pre-operation top, so it composes with push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            if (top_we_epc_i && !empty_o) mem_q[top_idx].epc <= top_wdata_i;
            if (top_we_esr_i && !empty_o) mem_q[top_idx].esr <= top_wdata_i;
            if (push_i && !full_o) begin
                mem_q[level_q[IW-1:0]] <= frame_i;
                level_q                <= level_q + LW'(1);
            end else if (pop_i && !empty_o) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/core_exc_ctrl.sv
// Exception/interrupt controller: prioritises events, vectors entry and
// keeps nested EPC/ESR frames on a small stack.
module core_exc_ctrl
    import core_pkg::*;
#(
    parameter int unsigned  NUM_IRQ    = 8,
    parameter int unsigned  NEST_DEPTH = 4,
    parameter int unsigned  AW         = 32,
    parameter int unsigned  VEC_BASE   = 32'h100,
    parameter int unsigned  VEC_STRIDE = 16,
    localparam int unsigned LW         = $clog2(NEST_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    input  logic [AW-1:0]      sr_i,
    input  logic               swi_i,
    input  logic               if_err_i,
    input  logic               id_err_i,
    input  logic               mau_err_i,
    input  logic [AW-1:0]      if_pc_i,
    input  logic [AW-1:0]      id_pc_i,
    input  logic [AW-1:0]      ex_pc_i,
    input  logic               rfe_i,
    input  logic               wb_spr_i,
    input  logic [4:0]         spr_addr_i,
    input  logic [AW-1:0]      spr_wdata_i,
    input  logic               mau_busy_i,
    output logic               set_pc_o,
    output logic [AW-1:0]      new_pc_o,
    output logic               id_flush_o,
    output logic               ex_flush_o,
    output logic               if_halt_o,
    output logic               id_halt_o,
    output logic               ex_halt_o,
    output logic               write_sr_o,
    output logic [AW-1:0]      wb_sr_o,
    output logic [AW-1:0]      epc_o,
    output logic [AW-1:0]      esr_o,
    output logic [LW-1:0]      nest_level_o,
    output logic               stk_ovf_o
);

    typedef enum logic [1:0] {ST_RUN, ST_ENTER, ST_RETURN} state_e;

    localparam int unsigned   VW        = 6;
    localparam logic [VW-1:0] V_SWI     = VW'(NUM_IRQ);
    localparam logic [VW-1:0] V_IF_ERR  = VW'(NUM_IRQ + 1);
    localparam logic [VW-1:0] V_ID_ERR  = VW'(NUM_IRQ + 2);
    localparam logic [VW-1:0] V_MAU_ERR = VW'(NUM_IRQ + 3);
    localparam logic [VW-1:0] V_FATAL   = VW'(NUM_IRQ + 4);

    function automatic logic [AW-1:0] vec_pc(input logic [VW-1:0] v);
        return AW'(VEC_BASE) + AW'(v) * AW'(VEC_STRIDE);
    endfunction

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   imask_q, imask_d, isr_q, isr_d, irq_ack_q, irq_ack_d;
    logic                 ovf_q, ovf_d, push_q, push_d;
    exc_frame_t           frame_q, frame_d;
    logic                 set_pc_q, set_pc_d, id_flush_q, id_flush_d;
    logic                 ex_flush_q, ex_flush_d, write_sr_q, write_sr_d;
    logic [AW-1:0]        new_pc_q, new_pc_d, wb_sr_q, wb_sr_d;

    exc_frame_t           stk_top;
    logic                 stk_full, stk_empty, stk_push, stk_pop;
    logic [LW-1:0]        stk_level;

    logic                 irq_hit, blocked;
    logic [IRQ_IDX_W-1:0] irq_idx;
    logic [NUM_IRQ-1:0]   irq_onehot;
    exc_cause_e           cause;
    logic [AW-1:0]        exc_pc;
    logic [VW-1:0]        vec;

    core_exc_stack #(.DEPTH(NEST_DEPTH)) u_stack (
        .clk          (clk),
        .rst          (rst),
        .push_i       (stk_push),
        .pop_i        (stk_pop),
        .frame_i      (frame_q),
        .top_we_epc_i (wb_spr_i && (spr_addr_i == SPR_EPC)),
        .top_we_esr_i (wb_spr_i && (spr_addr_i == SPR_ESR)),
        .top_wdata_i  (spr_wdata_i),
        .top_o        (stk_top),
        .full_o       (stk_full),
        .empty_o      (stk_empty),
        .level_o      (stk_level)
    );

    // Lowest eligible irq; any in-service bit at or above its priority blocks it.
    always_comb begin
        blocked    = 1'b0;
        irq_hit    = 1'b0;
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            blocked = blocked | isr_q[i];
            if (!irq_hit && irq_i[i] && imask_q[i] && !blocked && sr_i[SR_I] && !stk_full) begin
                irq_hit       = 1'b1;
                irq_idx       = IRQ_IDX_W'(i);
                irq_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cause  = CAUSE_NONE;
        exc_pc = '0;
        vec    = '0;
        if (mau_err_i) begin
            cause = CAUSE_MAU_ERR; exc_pc = ex_pc_i; vec = V_MAU_ERR;
        end else if (id_err_i || (rfe_i && stk_empty && !swi_i && !if_err_i && !irq_hit)) begin
            cause = CAUSE_ID_ERR;  exc_pc = id_pc_i; vec = V_ID_ERR;
        end else if (if_err_i) begin
            cause = CAUSE_IF_ERR;  exc_pc = if_pc_i; vec = V_IF_ERR;
        end else if (swi_i) begin
            cause = CAUSE_SWI;     exc_pc = id_pc_i; vec = V_SWI;
        end else if (irq_hit) begin
            cause = CAUSE_IRQ;     exc_pc = id_pc_i; vec = VW'(irq_idx);
        end else if (rfe_i) begin
            cause = CAUSE_RFE;
        end
    end

    always_comb begin
        state_d    = state_q;
        imask_d    = imask_q;
        isr_d      = isr_q;
        ovf_d      = ovf_q;
        push_d     = 1'b0;
        frame_d    = frame_q;
        irq_ack_d  = '0;
        set_pc_d   = 1'b0;
        new_pc_d   = '0;
        id_flush_d = 1'b0;
        ex_flush_d = 1'b0;
        write_sr_d = 1'b0;
        wb_sr_d    = '0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;

        if (wb_spr_i && (spr_addr_i == SPR_IMASK)) imask_d = spr_wdata_i[NUM_IRQ-1:0];
        if (wb_spr_i && (spr_addr_i == SPR_ISTAT) && spr_wdata_i[0]) ovf_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!mau_busy_i && (cause == CAUSE_RFE)) begin
                    state_d    = ST_RETURN;
                    set_pc_d   = 1'b1;
                    id_flush_d = 1'b1;
                    write_sr_d = 1'b1;
                    // Forward a same-cycle SPR write so the return uses the updated frame.
                    new_pc_d   = (wb_spr_i && spr_addr_i == SPR_EPC) ? spr_wdata_i : stk_top.epc;
                    wb_sr_d    = (wb_spr_i && spr_addr_i == SPR_ESR) ? spr_wdata_i : stk_top.esr;
                end else if (!mau_busy_i && (cause != CAUSE_NONE)) begin
                    state_d        = ST_ENTER;
                    set_pc_d       = 1'b1;
                    id_flush_d     = 1'b1;
                    ex_flush_d     = (cause != CAUSE_IF_ERR);
                    write_sr_d     = 1'b1;
                    wb_sr_d        = sr_i & ~(AW'(1) << SR_I);
                    irq_ack_d      = (cause == CAUSE_IRQ) ? irq_onehot : '0;
                    frame_d.epc    = exc_pc;
                    frame_d.esr    = sr_i;
                    frame_d.is_irq = (cause == CAUSE_IRQ);
                    frame_d.irq_idx = (cause == CAUSE_IRQ) ? irq_idx : '0;
                    if (stk_full) begin
                        new_pc_d = vec_pc(V_FATAL);
                        ovf_d    = 1'b1;
                    end else begin
                        new_pc_d = vec_pc(vec);
                        push_d   = 1'b1;
                    end
                end
            end
            ST_ENTER: begin
                stk_push = push_q;
                for (int i = 0; i < NUM_IRQ; i++)
                    if (push_q && frame_q.is_irq && (frame_q.irq_idx == IRQ_IDX_W'(i))) isr_d[i] = 1'b1;
                state_d = ST_RUN;
            end
            ST_RETURN: begin
                stk_pop = 1'b1;
                for (int i = 0; i < NUM_IRQ; i++)
                    if (stk_top.is_irq && (stk_top.irq_idx == IRQ_IDX_W'(i))) isr_d[i] = 1'b0;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            imask_q    <= '0;
            isr_q      <= '0;
            ovf_q      <= 1'b0;
            push_q     <= 1'b0;
            frame_q    <= '0;
            irq_ack_q  <= '0;
            set_pc_q   <= 1'b0;
            new_pc_q   <= '0;
            id_flush_q <= 1'b0;
            ex_flush_q <= 1'b0;
            write_sr_q <= 1'b0;
            wb_sr_q    <= '0;
        end else begin
            state_q    <= state_d;
            imask_q    <= imask_d;
            isr_q      <= isr_d;
            ovf_q      <= ovf_d;
            push_q     <= push_d;
            frame_q    <= frame_d;
            irq_ack_q  <= irq_ack_d;
            set_pc_q   <= set_pc_d;
            new_pc_q   <= new_pc_d;
            id_flush_q <= id_flush_d;
            ex_flush_q <= ex_flush_d;
            write_sr_q <= write_sr_d;
            wb_sr_q    <= wb_sr_d;
        end
    end

    assign irq_ack_o    = irq_ack_q;
    assign set_pc_o     = set_pc_q;
    assign new_pc_o     = new_pc_q;
    assign id_flush_o   = id_flush_q;
    assign ex_flush_o   = ex_flush_q;
    assign write_sr_o   = write_sr_q;
    assign wb_sr_o      = wb_sr_q;
    assign epc_o        = stk_top.epc;
    assign esr_o        = stk_top.esr;
    assign nest_level_o = stk_level;
    assign stk_ovf_o    = ovf_q;
    assign if_halt_o    = mau_busy_i;
    assign id_halt_o    = mau_busy_i;
    assign ex_halt_o    = mau_busy_i;

endmodule

// File: doc/core_exc_ctrl.md
# core_exc_ctrl

Parametrised exception and interrupt controller for the i2d core. It supports NUM_IRQ prioritised, maskable interrupt lines with vectored entry and nested exceptions through a NEST_DEPTH-deep EPC/ESR frame stack. It sits beside the decode stage and drives PC redirect, pipeline flush/halt and SR writeback. It replaces the single-level, single-irq exception logic.

## Interface
Parameters:
- NUM_IRQ, 8: interrupt lines, index 0 highest priority (1..32).
- NEST_DEPTH, 4: frame-stack depth (power of two, ≥2).
- AW, 32: address/data width.
- VEC_BASE, 32'h100: vector table base.
- VEC_STRIDE, 16: bytes per vector slot.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- irq in NUM_IRQ: level interrupt requests.
- irq_ack out NUM_IRQ: one-hot, one-cycle acknowledge.
- sr in AW: current status register; bit SR_I is the global irq enable.
- swi, if_err, id_err, mau_err in 1 each: exception requests, held until flushed.
- if_pc, id_pc, ex_pc in AW: stage PCs.
- rfe in 1: return-from-exception in decode.
- wb_spr in 1; spr_addr in 5; spr_wdata in AW: SPR write port.
- mau_busy in 1: memory unit stall.
- set_pc out 1; new_pc out AW: redirect.
- id_flush, ex_flush out 1: flush decode/execute.
- if_halt, id_halt, ex_halt out 1: stall.
- write_sr out 1; wb_sr out AW: SR writeback.
- epc, esr out AW: top-of-stack frame (0 when empty).
- nest_level out $clog2(NEST_DEPTH)+1: frames in use.
- stk_ovf out 1: sticky overflow flag.

## Operation
- FSM states:
  - RUN: sample events.
  - ENTER: 1 cycle; redirect, push, ack.
  - RETURN: 1 cycle; pop, redirect.
- Events are sampled only in RUN with mau_busy=0. Otherwise they are ignored and the sources keep them asserted.
- Priority (high→low): mau_err, id_err, if_err, swi, irq, rfe.
- An irq is eligible when:
  - irq[i] & imask[i], and
  - sr[SR_I]=1, and
  - no in-service bit j ≤ i is set.
  The lowest eligible index wins.
- EPC source: mau_err→ex_pc; if_err→if_pc; id_err/swi/irq→id_pc.
- Vector index v:
  - irq i → i
  - swi → NUM_IRQ
  - if_err → NUM_IRQ+1
  - id_err → NUM_IRQ+2
  - mau_err → NUM_IRQ+3
  - fatal → NUM_IRQ+4
  new_pc = VEC_BASE + v·VEC_STRIDE, computed mod 2^AW.
- ENTER:
  - Push frame {epc, sr, is_irq, irq_idx}; set in-service[idx] for irqs; pulse irq_ack[idx].
  - write_sr=1 with wb_sr = sr with SR_I cleared.
  - set_pc=1; id_flush=1. ex_flush=1 except for if_err, where ex_flush=0.
- Stack full at entry:
  - irqs are not eligible.
  - swi/errors vector to fatal, do not push, and set stk_ovf.
- RETURN (rfe, stack non-empty):
  - Pop; new_pc=epc; write_sr=1; wb_sr=esr; set_pc=1; id_flush=1.
  - If the frame was an irq, clear its in-service bit.
- rfe with an empty stack is handled as id_err.
- SPR writes (wb_spr, RUN or ENTER idle cycle):
  - SPR_EPC / SPR_ESR overwrite the top frame (ignored when empty).
  - SPR_IMASK writes imask.
  - SPR_ISTAT write-1 clears stk_ovf.
  - An SPR write in the same cycle as a push/pop lands on the pre-operation top.
- Halts equal mau_busy (combinational), in every state.

## Timing
- Event sampled at edge N → ENTER during cycle N+1 (set_pc, flushes, ack, write_sr all valid in that cycle). New frame and nest_level are visible at N+2. FSM back to RUN at N+2.
- rfe sampled at N → RETURN outputs in cycle N+1.
- Back-to-back: a new event is sampled no earlier than the edge ending ENTER/RETURN.
- mau_busy rising during ENTER/RETURN does not abort it; that cycle completes.
- Reset (async, any state):
  - FSM=RUN; stack empty; nest_level=0; imask=0; in-service=0; stk_ovf=0.
  - All outputs 0, except halts, which follow mau_busy.

## Structure
- Package core_pkg adds:
  - SR_I bit index
  - SPR_EPC, SPR_ESR, SPR_IMASK, SPR_ISTAT
  - exc_cause_e enum
  - exc_frame_t struct {epc, esr, is_irq, irq_idx}
- Sub-module core_exc_stack: synchronous LIFO of exc_frame_t with push, pop, top-write, full, empty and level. Push and pop are mutually exclusive by construction.
- Priority encoder and vector arithmetic stay in the top module.

## Test plan
- imask=8'h0C, sr[SR_I]=1, irq=8'h0C, id_pc=0x40 → irq_ack=8'h04, new_pc=0x120, epc=0x40, wb_sr SR_I=0, nest_level=1.
- In irq2 handler with SR_I re-enabled: assert irq3 → no entry; assert irq0 → enter 0x100, nest_level=2. rfe twice → new_pc follows popped EPCs, in-service cleared.
- mau_err and swi in the same cycle, ex_pc=0x88 → mau_err vector 0x100+(NUM_IRQ+3)·16=0x1B0, epc=0x88, ex_flush=1.
- Fill all 4 frames with swi, then a fifth swi → new_pc=0x1C0 (fatal), stk_ovf=1, nest_level=4. ISTAT write 1 → stk_ovf=0.
- mau_busy=1 with id_err held for 3 cycles → halts=1, no set_pc. mau_busy falls → ENTER the next cycle.
- rst low mid-ENTER → all outputs and stack cleared immediately; rfe after reset → id_err vector.
